// File: rtl/times_table_rd_arbiter.sv
// times_table_rd_arbiter
// Round-robin arbiter that shares one AXI4-lite read port of the times_table
// product ROM between two requesters. Each grant runs one full AR + R
// transaction and returns the product tagged with the requester id.
// Optional feature macro: TT_RESP_CHECK_EN. When it is defined, a non-OKAY
// rresp raises err and forces the result to zero. When it is undefined, err
// is tied low and rresp is ignored.
//
// Handshake semantics: a transfer on an AXI channel happens on a rising edge
// where valid and ready are both 1. arvalid, once raised, stays high with
// araddr stable until that edge. rready is raised only in DATA. A requester
// holds req[i] and its operands until gnt[i] pulses. A req still high after
// gnt counts as a new request.
module times_table_rd_arbiter #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          RESULT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req,
    input  logic [2:0]          a0,
    input  logic [2:0]          b0,
    input  logic [2:0]          a1,
    input  logic [2:0]          b1,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic [RESULT_W-1:0] result,
    output logic                err,
    output logic [31:0]         m_axi_araddr,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [31:0]         m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state_q;
    logic [1:0]            gnt_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  done_id_q;
    logic [RESULT_W-1:0]   result_q;
    logic [31:0]           araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  id_q;
    logic                  rr_q;      // requester favoured when both ask

    logic                  win_d;
    logic [31:0]           araddr_d;
    logic                  resp_err;

    // Upper rdata bits carry nothing; rresp is only consumed by the optional check.
    logic                  unused_bits;
    assign unused_bits = ^{m_axi_rdata[31:RESULT_W], m_axi_rresp};

`ifdef TT_RESP_CHECK_EN
    assign resp_err = (m_axi_rresp != 2'b00);
`else
    assign resp_err = 1'b0;
`endif

    // Pick the winner and form its ROM byte address.
    always_comb begin
        win_d = rr_q;
        if (req == 2'b01) begin
            win_d = 1'b0;
        end else if (req == 2'b10) begin
            win_d = 1'b1;
        end
        if (win_d) begin
            araddr_d = ADDR_BASE + {24'd0, a1, b1, 2'b00};
        end else begin
            araddr_d = ADDR_BASE + {24'd0, a0, b0, 2'b00};
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            araddr_q  <= 32'd0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            id_q      <= 1'b0;
            rr_q      <= 1'b0;
        end else begin
            gnt_q  <= 2'b00;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt_q     <= win_d ? 2'b10 : 2'b01;
                        id_q      <= win_d;
                        rr_q      <= ~win_d;
                        araddr_q  <= araddr_d;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (m_axi_rvalid) begin
                        rready_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
                        result_q  <= resp_err ? '0 : m_axi_rdata[RESULT_W-1:0];
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef TT_RESP_CHECK_EN
    logic err_q;

    // Error flag, updated only when a result is delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == DATA && m_axi_rvalid) begin
            err_q <= resp_err;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt           = gnt_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign done_id       = done_id_q;
    assign result        = result_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign dbg_state     = state_q;

endmodule
